// File: rtl/adc_serial_responder_if.sv
// Serial pin bundle between the board ADC controller (master) and the ADC model (slave).
interface adc_serial_responder_if;
   logic sclk;
   logic cs_n;
   logic din;
   logic dout;

   modport master (output sclk, output cs_n, output din, input dout);
   modport slave  (input sclk, input cs_n, input din, output dout);
endinterface

// File: rtl/adc_serial_responder.sv
// Slave-side model of an 8-channel serial ADC (ADC128S022-style framing).
// SCLK/CS_N/DIN are oversampled in the system clock domain; data is returned MSB first.
//
//   state  | meaning
//   IDLE   | CS_N high, DOUT held low, SCLK edges ignored
//   ACTIVE | frame in progress: rising edges sample DIN, falling edges shift DOUT
module adc_serial_responder #(
   parameter int DATA_W  = 12,
   parameter int SYNC_ST = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] ch0,
   input  logic [DATA_W-1:0] ch1,
   input  logic [DATA_W-1:0] ch2,
   input  logic [DATA_W-1:0] ch3,
   input  logic [DATA_W-1:0] ch4,
   input  logic [DATA_W-1:0] ch5,
   input  logic [DATA_W-1:0] ch6,
   input  logic [DATA_W-1:0] ch7,
   adc_serial_responder_if.slave adc,
   output logic              frame_done,
   output logic [2:0]        last_addr,
   output logic              frame_err
);

   localparam int FRAME_W = DATA_W + 4;
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] BIT_TOP  = CNT_W'(FRAME_W - 2);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t             state;
   logic [SYNC_ST-1:0] sclk_sync, cs_sync, din_sync;
   logic               sclk_prev, cs_prev;
   logic               sclk_rise, sclk_fall, cs_rise, cs_fall, din_s;
   logic [FRAME_W-1:0] sr;
   logic [CNT_W-1:0]   fcnt, rcnt;
   logic [2:0]         addr;
   logic               seen_rise;
   logic               dout;
   logic [DATA_W-1:0]  ch_sel;

   // History clears to all-zero so a CS_N held low across reset cannot start a frame.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         din_sync  <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_ST-2:0], adc.sclk};
         cs_sync   <= {cs_sync[SYNC_ST-2:0], adc.cs_n};
         din_sync  <= {din_sync[SYNC_ST-2:0], adc.din};
         sclk_prev <= sclk_sync[SYNC_ST-1];
         cs_prev   <= cs_sync[SYNC_ST-1];
      end
   end

   assign sclk_rise = sclk_sync[SYNC_ST-1] & ~sclk_prev;
   assign sclk_fall = ~sclk_sync[SYNC_ST-1] & sclk_prev;
   assign cs_rise   = cs_sync[SYNC_ST-1] & ~cs_prev;
   assign cs_fall   = ~cs_sync[SYNC_ST-1] & cs_prev;
   assign din_s     = din_sync[SYNC_ST-1];

   always_comb begin
      ch_sel = ch0;
      case (last_addr)
         3'd0: ch_sel = ch0;
         3'd1: ch_sel = ch1;
         3'd2: ch_sel = ch2;
         3'd3: ch_sel = ch3;
         3'd4: ch_sel = ch4;
         3'd5: ch_sel = ch5;
         3'd6: ch_sel = ch6;
         3'd7: ch_sel = ch7;
         default: ch_sel = ch0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         sr         <= '0;
         fcnt       <= '0;
         rcnt       <= '0;
         addr       <= '0;
         seen_rise  <= 1'b0;
         dout       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         last_addr  <= '0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               dout <= 1'b0;
               if (cs_fall) begin
                  state     <= ACTIVE;
                  sr        <= {4'b0, ch_sel};
                  fcnt      <= '0;
                  rcnt      <= '0;
                  addr      <= '0;
                  seen_rise <= 1'b0;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state <= IDLE;
                  dout  <= 1'b0;
                  // A 16th rising edge coinciding with CS_N rise still completes the frame.
                  if (sclk_rise && rcnt == CNT_LAST) begin
                     last_addr  <= addr;
                     frame_done <= 1'b1;
                     rcnt       <= '0;
                  end else if (rcnt != '0 || !seen_rise) begin
                     frame_err <= 1'b1;
                  end
               end else if (sclk_rise) begin
                  seen_rise <= 1'b1;
                  case (rcnt)
                     CNT_W'(2): addr[2] <= din_s;
                     CNT_W'(3): addr[1] <= din_s;
                     CNT_W'(4): addr[0] <= din_s;
                     default: ;
                  endcase
                  if (rcnt == CNT_LAST) begin
                     last_addr  <= addr;
                     frame_done <= 1'b1;
                     rcnt       <= '0;
                  end else begin
                     rcnt <= rcnt + 1'b1;
                  end
               end else if (sclk_fall) begin
                  if (fcnt < CNT_LAST) begin
                     fcnt <= fcnt + 1'b1;
                     dout <= sr[BIT_TOP - fcnt];
                  end else begin
                     // Continuous mode: last_addr already holds this frame's address.
                     sr   <= {4'b0, ch_sel};
                     fcnt <= '0;
                     dout <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign adc.dout = dout;

endmodule
